// File: rtl/rps_match_controller.sv
// Match sequencer for a best-of-N stone-paper-scissors game.
// Collects one locked move per player per round, hands the pair to an
// external round judge, keeps score and declares the match winner.
// A round in which only one player locks before the collect timer expires
// is forfeited to that player without consulting the judge.
module rps_match_controller #(
  parameter int ROUNDS_TO_WIN  = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int SHOW_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_match,
  input  logic [1:0] p1_move,
  input  logic       p1_lock,
  input  logic [1:0] p2_move,
  input  logic       p2_lock,
  output logic       judge_req,
  output logic [1:0] judge_p1,
  output logic [1:0] judge_p2,
  input  logic       judge_done,
  input  logic [1:0] judge_winner,
  output logic [1:0] round_winner,
  output logic       round_valid,
  output logic       round_void,
  output logic [2:0] p1_score,
  output logic [2:0] p2_score,
  output logic [3:0] round_cnt,
  output logic       match_done,
  output logic [1:0] match_winner,
  output logic [2:0] state
);

  // state   | meaning
  // IDLE    | after reset, waiting for start_match
  // COLLECT | gathering locks from both players, timeout timer running
  // JUDGE   | judge_req high, waiting for judge_done
  // SHOW    | round result displayed for SHOW_CYCLES cycles
  // DONE    | match over, winner displayed until start_match
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_JUDGE   = 3'd2,
    ST_SHOW    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SHOW_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SHOW_LAST  = SW'(SHOW_CYCLES - 1);
  localparam logic [2:0]    WIN_SCORE  = 3'(ROUNDS_TO_WIN);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] show_q, show_d;
  logic          p1_lk_q, p1_lk_d;
  logic          p2_lk_q, p2_lk_d;
  logic          judge_req_q, judge_req_d;
  logic [1:0]    judge_p1_q, judge_p1_d;
  logic [1:0]    judge_p2_q, judge_p2_d;
  logic [1:0]    round_winner_q, round_winner_d;
  logic          round_valid_q, round_valid_d;
  logic          round_void_q, round_void_d;
  logic [2:0]    p1_score_q, p1_score_d;
  logic [2:0]    p2_score_q, p2_score_d;
  logic [3:0]    round_cnt_q, round_cnt_d;
  logic          match_done_q, match_done_d;
  logic [1:0]    match_winner_q, match_winner_d;

  logic          score_en;
  logic [1:0]    score_win;

  // Next-state and registered-output computation for the whole sequencer.
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    show_d         = show_q;
    p1_lk_d        = p1_lk_q;
    p2_lk_d        = p2_lk_q;
    judge_req_d    = judge_req_q;
    judge_p1_d     = judge_p1_q;
    judge_p2_d     = judge_p2_q;
    round_winner_d = round_winner_q;
    round_valid_d  = 1'b0;
    round_void_d   = 1'b0;
    p1_score_d     = p1_score_q;
    p2_score_d     = p2_score_q;
    round_cnt_d    = round_cnt_q;
    match_done_d   = match_done_q;
    match_winner_d = match_winner_q;
    score_en       = 1'b0;
    score_win      = 2'b00;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_match) begin
          state_d        = ST_COLLECT;
          p1_score_d     = 3'd0;
          p2_score_d     = 3'd0;
          round_cnt_d    = 4'd0;
          round_winner_d = 2'b00;
          p1_lk_d        = 1'b0;
          p2_lk_d        = 1'b0;
          timer_d        = '0;
          match_done_d   = 1'b0;
          match_winner_d = 2'b00;
        end
      end

      ST_COLLECT: begin
        if (p1_lock && !p1_lk_q) begin
          p1_lk_d    = 1'b1;
          judge_p1_d = p1_move;
        end
        if (p2_lock && !p2_lk_q) begin
          p2_lk_d    = 1'b1;
          judge_p2_d = p2_move;
        end
        // Completing both locks takes priority over an expiring timer.
        if (p1_lk_d && p2_lk_d) begin
          state_d     = ST_JUDGE;
          judge_req_d = 1'b1;
          timer_d     = '0;
        end else if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          if (p1_lk_d ^ p2_lk_d) begin
            state_d   = ST_SHOW;
            score_en  = 1'b1;
            score_win = p1_lk_d ? 2'b01 : 2'b10;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_JUDGE: begin
        if (judge_done) begin
          judge_req_d = 1'b0;
          if (judge_winner == 2'b11) begin
            state_d      = ST_COLLECT;
            round_void_d = 1'b1;
            p1_lk_d      = 1'b0;
            p2_lk_d      = 1'b0;
            timer_d      = '0;
          end else begin
            state_d   = ST_SHOW;
            score_en  = 1'b1;
            score_win = judge_winner;
          end
        end
      end

      ST_SHOW: begin
        if (show_q == SHOW_LAST) begin
          if (p1_score_q == WIN_SCORE || p2_score_q == WIN_SCORE) begin
            state_d        = ST_DONE;
            match_done_d   = 1'b1;
            match_winner_d = (p1_score_q == WIN_SCORE) ? 2'b01 : 2'b10;
          end else begin
            state_d = ST_COLLECT;
            p1_lk_d = 1'b0;
            p2_lk_d = 1'b0;
            timer_d = '0;
          end
        end else begin
          show_d = show_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A scored round (judged or forfeited) enters SHOW with the tally updated.
    if (score_en) begin
      round_valid_d  = 1'b1;
      round_winner_d = score_win;
      show_d         = '0;
      if (round_cnt_q != 4'd15) round_cnt_d = round_cnt_q + 4'd1;
      if (score_win == 2'b01) p1_score_d = p1_score_q + 3'd1;
      if (score_win == 2'b10) p2_score_d = p2_score_q + 3'd1;
    end
  end

  // State and output registers; reset aborts any round in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      show_q         <= '0;
      p1_lk_q        <= 1'b0;
      p2_lk_q        <= 1'b0;
      judge_req_q    <= 1'b0;
      judge_p1_q     <= 2'b00;
      judge_p2_q     <= 2'b00;
      round_winner_q <= 2'b00;
      round_valid_q  <= 1'b0;
      round_void_q   <= 1'b0;
      p1_score_q     <= 3'd0;
      p2_score_q     <= 3'd0;
      round_cnt_q    <= 4'd0;
      match_done_q   <= 1'b0;
      match_winner_q <= 2'b00;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      show_q         <= show_d;
      p1_lk_q        <= p1_lk_d;
      p2_lk_q        <= p2_lk_d;
      judge_req_q    <= judge_req_d;
      judge_p1_q     <= judge_p1_d;
      judge_p2_q     <= judge_p2_d;
      round_winner_q <= round_winner_d;
      round_valid_q  <= round_valid_d;
      round_void_q   <= round_void_d;
      p1_score_q     <= p1_score_d;
      p2_score_q     <= p2_score_d;
      round_cnt_q    <= round_cnt_d;
      match_done_q   <= match_done_d;
      match_winner_q <= match_winner_d;
    end
  end

  assign state        = state_q;
  assign judge_req    = judge_req_q;
  assign judge_p1     = judge_p1_q;
  assign judge_p2     = judge_p2_q;
  assign round_winner = round_winner_q;
  assign round_valid  = round_valid_q;
  assign round_void   = round_void_q;
  assign p1_score     = p1_score_q;
  assign p2_score     = p2_score_q;
  assign round_cnt    = round_cnt_q;
  assign match_done   = match_done_q;
  assign match_winner = match_winner_q;

endmodule

// File: tb/tb_rps_match_controller.sv
// Bench for rps_match_controller: stimulus computes each round's outcome from
// the game rules and pushes it to a scoreboard; a monitor pops and compares
// whenever the controller reports a scored, voided or finished round.
module tb_rps_match_controller;

  localparam int RTW = 2;
  localparam int T   = 12;
  localparam int SC  = 3;

  logic       clk = 1'b0;
  logic       rst, start_match, p1_lock, p2_lock, judge_done;
  logic [1:0] p1_move, p2_move, judge_winner;
  logic       judge_req, round_valid, round_void, match_done;
  logic [1:0] judge_p1, judge_p2, round_winner, match_winner;
  logic [2:0] p1_score, p2_score, state;
  logic [3:0] round_cnt;

  rps_match_controller #(
    .ROUNDS_TO_WIN(RTW), .TIMEOUT_CYCLES(T), .SHOW_CYCLES(SC)
  ) dut (
    .clk(clk), .rst(rst), .start_match(start_match),
    .p1_move(p1_move), .p1_lock(p1_lock), .p2_move(p2_move), .p2_lock(p2_lock),
    .judge_req(judge_req), .judge_p1(judge_p1), .judge_p2(judge_p2),
    .judge_done(judge_done), .judge_winner(judge_winner),
    .round_winner(round_winner), .round_valid(round_valid), .round_void(round_void),
    .p1_score(p1_score), .p2_score(p2_score), .round_cnt(round_cnt),
    .match_done(match_done), .match_winner(match_winner), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // kind: 0 scored round, 1 voided round, 2 match finished
  typedef struct {
    int kind;
    int win;
    int p1;
    int p2;
    int cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   mp1, mp2, mcnt;
  int   req_cycles = 0;
  bit   done_prev = 0;

  // Monitor: compare every reported event against the scoreboard head.
  always @(negedge clk) begin
    if (judge_req) req_cycles++;
    if (round_valid || round_void) begin
      if (sb.size() == 0) check("sb_underflow_round", 1, 0);
      else begin
        mon_e = sb.pop_front();
        check("event_kind", round_void ? 1 : 0, mon_e.kind);
        if (round_valid) begin
          check("round_winner", round_winner, mon_e.win);
          check("state_show", state, 3);
        end else begin
          check("state_after_void", state, 1);
        end
        check("p1_score", p1_score, mon_e.p1);
        check("p2_score", p2_score, mon_e.p2);
        check("round_cnt", round_cnt, mon_e.cnt);
      end
    end
    if (match_done && !done_prev) begin
      if (sb.size() == 0) check("sb_underflow_done", 1, 0);
      else begin
        mon_e = sb.pop_front();
        check("done_kind", 2, mon_e.kind);
        check("match_winner", match_winner, mon_e.win);
        check("final_p1", p1_score, mon_e.p1);
        check("final_p2", p2_score, mon_e.p2);
        check("state_done", state, 4);
      end
    end
    done_prev = match_done;
  end

  function automatic int rps(input int a, input int b);
    if (a == 3 || b == 3) return 3;
    if (a == b) return 0;
    if ((a - b + 3) % 3 == 1) return 1;
    return 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int win);
    exp_t e;
    e.kind = kind; e.win = win; e.p1 = mp1; e.p2 = mp2; e.cnt = mcnt;
    sb.push_back(e);
  endtask

  task automatic model_score(input int w);
    if (w == 3) push(1, 3);
    else begin
      mcnt = (mcnt < 15) ? mcnt + 1 : 15;
      if (w == 1) mp1++;
      if (w == 2) mp2++;
      push(0, w);
      if (mp1 == RTW) push(2, 1);
      else if (mp2 == RTW) push(2, 2);
    end
  endtask

  task automatic start_new();
    start_match = 1'b1;
    tick();
    start_match = 1'b0;
    mp1 = 0; mp2 = 0; mcnt = 0;
    check("start_state", state, 1);
    check("start_p1", p1_score, 0);
    check("start_p2", p2_score, 0);
    check("start_cnt", round_cnt, 0);
    check("start_done", match_done, 0);
    check("start_winner", match_winner, 0);
  endtask

  // t1/t2: COLLECT cycle index at which each player locks, -1 = never.
  // noisy adds ignored relocks with other moves and stray start_match pulses.
  task automatic do_round(input int m1, input int m2, input int t1, input int t2, input bit noisy);
    int first, second, firstp, base, w, c, d, req0;
    bit judged;
    if (t1 < 0) begin first = t2; firstp = 2; second = -1; end
    else if (t2 < 0) begin first = t1; firstp = 1; second = -1; end
    else if (t1 <= t2) begin first = t1; firstp = 1; second = t2; end
    else begin first = t2; firstp = 2; second = t1; end
    base   = (first / T) * T;
    judged = (second >= 0) && (second <= base + T - 1);
    w      = judged ? rps(m1, m2) : firstp;
    model_score(w);
    req0 = req_cycles;
    c = 0;
    while (state == 3'd1 && c < 4 * T + 8) begin
      p1_move = (t1 < 0 || c <= t1) ? 2'(m1) : 2'($urandom_range(0, 3));
      p2_move = (t2 < 0 || c <= t2) ? 2'(m2) : 2'($urandom_range(0, 3));
      p1_lock = (t1 >= 0) && (c == t1 || (c > t1 && noisy && $urandom_range(0, 1) == 1));
      p2_lock = (t2 >= 0) && (c == t2 || (c > t2 && noisy && $urandom_range(0, 1) == 1));
      start_match = noisy && ($urandom_range(0, 3) == 0);
      tick();
      c++;
    end
    p1_lock = 1'b0; p2_lock = 1'b0; start_match = 1'b0;
    if (judged) begin
      check("enter_judge", state, 2);
      check("judge_req_high", judge_req, 1);
      check("judge_p1", judge_p1, m1);
      check("judge_p2", judge_p2, m2);
      d = $urandom_range(0, 3);
      repeat (d) begin
        start_match = noisy && ($urandom_range(0, 1) == 1);
        tick();
      end
      start_match = 1'b0;
      check("judge_req_held", judge_req, 1);
      check("judge_p1_held", judge_p1, m1);
      judge_done = 1'b1;
      judge_winner = 2'(w);
      tick();
      judge_done = 1'b0;
      judge_winner = 2'b00;
      check("judge_req_drop", judge_req, 0);
    end else begin
      check("forfeit_show", state, 3);
      check("forfeit_no_req", req_cycles - req0, 0);
    end
    c = 0;
    while (!(state == 3'd1 || state == 3'd4) && c < SC + 4) begin
      start_match = noisy && ($urandom_range(0, 1) == 1);
      tick();
      c++;
    end
    start_match = 1'b0;
    check("round_end_bound", (state == 3'd1 || state == 3'd4) ? 1 : 0, 1);
  endtask

  task automatic random_round();
    int m1, m2, t1, t2;
    m1 = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
    m2 = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
    t1 = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, T + 4));
    t2 = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, T + 4));
    if (t1 < 0 && t2 < 0) t2 = int'($urandom_range(0, T + 4));
    do_round(m1, m2, t1, t2, 1'b1);
  endtask

  task automatic finish_match();
    int n;
    n = 0;
    while (mp1 != RTW && mp2 != RTW && n < 40) begin
      random_round();
      n++;
    end
    check("match_finished", state, 4);
  endtask

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_match = 1'b0; p1_lock = 1'b0; p2_lock = 1'b0;
    p1_move = 2'b00; p2_move = 2'b00; judge_done = 1'b0; judge_winner = 2'b00;
    mp1 = 0; mp2 = 0; mcnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state, 0);
    check("rst_req", judge_req, 0);
    check("rst_done", match_done, 0);
    check("rst_cnt", round_cnt, 0);
    check("rst_rwin", round_winner, 0);
    rst = 1'b0;
    tick();
    check("idle_hold", state, 0);

    // Match 1: P1 wins two straight rounds.
    start_new();
    do_round(0, 2, 2, 3, 1'b0);
    do_round(1, 0, 0, 0, 1'b0);
    check("m1_state", state, 4);
    check("m1_winner", match_winner, 1);

    // Match 2: directed corner cases, then random rounds to finish.
    start_new();
    do_round(1, 1, 1, 4, 1'b0);
    do_round(3, 0, 0, 2, 1'b0);
    do_round(0, 2, 0, T - 1, 1'b0);
    do_round(0, 1, -1, 3, 1'b0);
    do_round(1, 1, T + 2, T + 5, 1'b0);
    finish_match();

    // Fully random matches.
    for (int k = 0; k < 4; k++) begin
      start_new();
      finish_match();
    end

    // Reset in the middle of a judge request.
    start_new();
    p1_move = 2'b01; p2_move = 2'b10; p1_lock = 1'b1; p2_lock = 1'b1;
    tick();
    p1_lock = 1'b0; p2_lock = 1'b0;
    check("abort_in_judge", state, 2);
    check("abort_req_high", judge_req, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_req_drop", judge_req, 0);
    check("abort_state", state, 0);
    check("abort_jp1", judge_p1, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    mp1 = 0; mp2 = 0; mcnt = 0;
    tick();
    check("abort_idle", state, 0);
    start_new();
    do_round(2, 1, 1, 1, 1'b0);

    repeat (3) tick();
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rps_match_controller.md
Name: rps_match_controller

Overview:
- Sequences a best-of-N stone-paper-scissors match around the shared round judge (the combinational/registered winner datapath).
- Collects and locks each player's move independently, issues one judge request per round and keeps the score.
- Applies a per-round lock timeout with forfeit, and declares the match winner.
- Sits between the ui_in decode logic and the uo_out display mux in the tt_um top.

Parameters:
ROUNDS_TO_WIN, 2, round wins needed to take the match (1..7; default is best of 3)
TIMEOUT_CYCLES, 255, cycles allowed in COLLECT before timeout action (>=2)
SHOW_CYCLES, 4, cycles the round result is held in SHOW (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start_match  input  1  level sampled; starts a new match from IDLE or DONE, ignored elsewhere
p1_move  input  2  player 1 move (00 stone, 01 paper, 10 scissors, 11 illegal)
p1_lock  input  1  player 1 commits current p1_move
p2_move  input  2  player 2 move, same encoding
p2_lock  input  1  player 2 commits current p2_move
judge_req  output  1  request to judge; held until judge_done
judge_p1  output  2  latched P1 move to judge
judge_p2  output  2  latched P2 move to judge
judge_done  input  1  judge result valid this cycle
judge_winner  input  2  00 tie, 01 P1, 10 P2, 11 invalid
round_winner  output  2  result of last completed round (same encoding)
round_valid  output  1  one-cycle pulse when a round is scored
round_void  output  1  one-cycle pulse when a round is discarded (invalid)
p1_score  output  3  P1 rounds won this match
p2_score  output  3  P2 rounds won this match
round_cnt  output  4  rounds scored this match (ties included), saturates at 15
match_done  output  1  high in DONE
match_winner  output  2  01 P1, 10 P2, 00 while not DONE
state  output  3  IDLE=0, COLLECT=1, JUDGE=2, SHOW=3, DONE=4

Behaviour:
- Reset: all outputs 0, state IDLE, internal locks/timer cleared. Reset asserted in any state, including mid-JUDGE with judge_req high, drops judge_req immediately and aborts the round. No score is kept.
- IDLE/DONE + start_match=1: clear scores, round_cnt, locks and timer; enter COLLECT next cycle. match_done and match_winner go to 0 on that edge.
- COLLECT:
  - Timer increments each cycle from 0.
  - pX_lock=1 while X is unlocked latches pX_move into judge_pX. Later locks by an already-locked player are ignored.
  - When both are locked, including both locking in the same cycle, enter JUDGE next cycle.
  - Timer == TIMEOUT_CYCLES-1 with exactly one player locked is a forfeit: round_winner = that player, go to SHOW, judge bypassed.
  - Timer == TIMEOUT_CYCLES-1 with neither locked: timer reset to 0, stay in COLLECT, no score.
  - A lock that completes both locks in the timeout cycle wins over the timeout: go to JUDGE.
- JUDGE:
  - judge_req=1; judge_p1/judge_p2 held stable until judge_done.
  - judge_done with winner 00/01/10: capture into round_winner, enter SHOW.
  - judge_done with 11: round_void pulses on the next cycle, locks and timer clear, return to COLLECT. Scores and round_cnt unchanged.
  - judge_req deasserts in the cycle after judge_done.
  - No timeout in JUDGE.
- SHOW entry cycle:
  - round_valid=1 for exactly one cycle.
  - round_cnt increments, saturating at 15.
  - Winner's score increments; a tie scores nobody.
  - round_winner holds until the next scored round or a new match.
- SHOW lasts SHOW_CYCLES cycles. Then:
  - If p1_score or p2_score == ROUNDS_TO_WIN: enter DONE, match_winner set.
  - Otherwise: return to COLLECT with locks and timer cleared.
- DONE: match_done=1, scores frozen, stays until start_match.
- Score width 3 bits; the ROUNDS_TO_WIN cap means scores never exceed it.

Test Plan:
- Reset, start_match; rounds (00,10) then (01,00) with judge answering 01 -> two round_valid pulses, p1_score=2, p2_score=0, round_cnt=2, DONE, match_winner=01.
- Round (01,01), judge 00 -> round_valid pulse, round_winner=00, scores unchanged, round_cnt=1, back to COLLECT.
- Round (11,00), judge 11 -> round_void pulse, no round_valid, round_cnt=0, COLLECT with locks cleared.
- Only p2_lock asserted, wait TIMEOUT_CYCLES -> SHOW with judge_req never high, round_winner=10, p2_score=1. Neither locked -> stays in COLLECT, timer restarts.
- p1 locked early, p2_lock lands on the timeout cycle -> JUDGE entered, no forfeit.
- rst pulse while judge_req=1 -> judge_req=0 immediately, all outputs 0, IDLE. start_match during COLLECT/JUDGE/SHOW is ignored.
